// File: rtl/t06_snake_pkg.sv
// Shared types and defaults for the snake body block.
//   dir_t       : heading encoding, matches the dir_req port encoding
//   state_t     : game FSM states
//   EMPTY_COORD : value parked in unused segment slots (never a legal cell)
//   opposite_dir: the 180-degree reversal of a heading
package t06_snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } state_t;

    localparam logic [3:0] EMPTY_COORD  = 4'hF;
    localparam int         MAX_LENGTH_DEF = 30;
    localparam int         GRID_MAX_DEF   = 14;

    // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/t06_snake_body_next_head.sv
// Combinational next-head calculator.
//   head_x/head_y : current head cell
//   heading       : current registered heading
//   dir_req       : requested heading (reversal is ignored)
//   next_head     : {y,x} of the cell entered on the next tick (head itself on wall)
//   heading_eff   : heading that the next tick will adopt
//   wall          : the step would leave 0..GRID_MAX
module t06_next_head_calc
    import t06_snake_pkg::*;
#(
    parameter int GRID_MAX = GRID_MAX_DEF
) (
    input  logic [3:0] head_x,
    input  logic [3:0] head_y,
    input  dir_t       heading,
    input  logic [1:0] dir_req,
    output logic [7:0] next_head,
    output dir_t       heading_eff,
    output logic       wall
);

    localparam logic [3:0] GMAX = 4'(GRID_MAX);

    logic [3:0] step_x;
    logic [3:0] step_y;

    always_comb begin
        heading_eff = (dir_t'(dir_req) == opposite_dir(heading)) ? heading : dir_t'(dir_req);
        step_x = head_x;
        step_y = head_y;
        wall   = 1'b0;
        case (heading_eff)
            UP: begin
                wall   = (head_y == 4'd0);
                step_y = head_y - 4'd1;
            end
            DOWN: begin
                wall   = (head_y == GMAX);
                step_y = head_y + 4'd1;
            end
            LEFT: begin
                wall   = (head_x == 4'd0);
                step_x = head_x - 4'd1;
            end
            RIGHT: begin
                wall   = (head_x == GMAX);
                step_x = head_x + 4'd1;
            end
            default: wall = 1'b0;
        endcase
        // On a wall the head stays put so the collision unit sees a legal cell.
        next_head = wall ? {head_y, head_x} : {step_y, step_x};
    end

endmodule

// File: rtl/t06_snake_body.sv
// Snake body owner: segment array, heading, length/grow bookkeeping and
// the IDLE/RUN/DEAD game FSM.
//   clk, rst      : clock, synchronous active-high reset
//   tick          : move strobe (only acted on in RUN)
//   dir_req       : requested heading
//   grow          : apple-eaten pulse, remembered until the next RUN tick
//   start         : IDLE->RUN, DEAD->IDLE with reset layout
//   collision     : combinational result from the collision unit
//   next_head     : {y,x} cell the head enters on the next tick
//   body_x/body_y : slot i coordinate at [i*4 +: 4], slot 0 = head
//   length        : live segments including head
//   game_over     : high while DEAD
module t06_snake_body
    import t06_snake_pkg::*;
#(
    parameter int MAX_LENGTH  = MAX_LENGTH_DEF,
    parameter int INIT_LENGTH = 3,
    parameter int GRID_MAX    = GRID_MAX_DEF,
    parameter int START_X     = 7,
    parameter int START_Y     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [1:0]              dir_req,
    input  logic                    grow,
    input  logic                    start,
    input  logic                    collision,
    output logic [7:0]              next_head,
    output logic [MAX_LENGTH*4-1:0] body_x,
    output logic [MAX_LENGTH*4-1:0] body_y,
    output logic [4:0]              length,
    output logic                    game_over
);

    localparam logic [4:0] LEN_MAX  = 5'(MAX_LENGTH);
    localparam logic [4:0] LEN_INIT = 5'(INIT_LENGTH);

    logic [3:0] slot_x [MAX_LENGTH];
    logic [3:0] slot_y [MAX_LENGTH];
    state_t     state;
    dir_t       heading;
    dir_t       heading_eff;
    logic [4:0] len_q;
    logic       grow_pend;
    logic       wall;
    logic       grow_ok;
    logic       reload;

    t06_next_head_calc #(.GRID_MAX(GRID_MAX)) u_next_head (
        .head_x     (slot_x[0]),
        .head_y     (slot_y[0]),
        .heading    (heading),
        .dir_req    (dir_req),
        .next_head  (next_head),
        .heading_eff(heading_eff),
        .wall       (wall)
    );

    // A grow arriving with the tick counts for that tick.
    assign grow_ok = (grow_pend | grow) && (len_q < LEN_MAX);
    assign reload  = rst || (state == DEAD && start);

    always_ff @(posedge clk) begin
        if (reload) begin
            state     <= IDLE;
            heading   <= RIGHT;
            len_q     <= LEN_INIT;
            grow_pend <= 1'b0;
            game_over <= 1'b0;
            for (int i = 0; i < MAX_LENGTH; i++) begin
                if (i < INIT_LENGTH) begin
                    slot_x[i] <= 4'(START_X - i);
                    slot_y[i] <= 4'(START_Y);
                end else begin
                    slot_x[i] <= EMPTY_COORD;
                    slot_y[i] <= EMPTY_COORD;
                end
            end
        end else begin
            if (grow) grow_pend <= 1'b1;
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: begin
                    if (tick) begin
                        if (collision || wall) begin
                            // Body, length and heading stay frozen for the post-mortem view.
                            state     <= DEAD;
                            game_over <= 1'b1;
                        end else begin
                            heading   <= heading_eff;
                            grow_pend <= 1'b0;
                            slot_x[0] <= next_head[3:0];
                            slot_y[0] <= next_head[7:4];
                            // Shift; when not growing the slot just past the old tail is
                            // vacated. At full length the old tail simply falls off the end.
                            for (int i = 1; i < MAX_LENGTH; i++) begin
                                if (!grow_ok && i == int'(len_q)) begin
                                    slot_x[i] <= EMPTY_COORD;
                                    slot_y[i] <= EMPTY_COORD;
                                end else begin
                                    slot_x[i] <= slot_x[i-1];
                                    slot_y[i] <= slot_y[i-1];
                                end
                            end
                            if (grow_ok) len_q <= len_q + 5'd1;
                        end
                    end
                end
                DEAD:    game_over <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    assign length = len_q;

    for (genvar g = 0; g < MAX_LENGTH; g++) begin : g_flat
        assign body_x[g*4 +: 4] = slot_x[g];
        assign body_y[g*4 +: 4] = slot_y[g];
    end

endmodule
